audio_loop_buffer: RTL
======================

Name: audio_loop_buffer

Overview:
- Parametrised successor to the codec passthrough glue.
- Sits between the audio_codec read/write handshake and the rest of the design.
- Moves one stereo frame per codec-ready event through a registered FSM, unlike the old combinational passthrough.
- Adds multi-channel width generalisation, mute, record-to-buffer and looped playback modes, plus an attenuation shift.

Parameters:
- DATA_W, 24, sample width per channel (matches codec readdata/writedata).
- DEPTH, 1024, frames held in the record buffer (power of two, ≥2).
- ADDR_W, $clog2(DEPTH), buffer address width (derived; do not override).

Ports:
- CLOCK_50  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- mode  in  2  00 passthrough, 01 mute, 10 record, 11 playback.
- vol_shift  in  3  arithmetic right-shift applied to the output samples (0 = unity).
- read_ready  in  1  codec ADC FIFO has a frame.
- write_ready  in  1  codec DAC FIFO has space.
- readdata_left  in  DATA_W  codec left input sample.
- readdata_right  in  DATA_W  codec right input sample.
- read  out  1  pop strobe to codec, 1 cycle.
- write  out  1  push strobe to codec, 1 cycle.
- writedata_left  out  DATA_W  left sample to codec.
- writedata_right  out  DATA_W  right sample to codec.
- rec_len  out  ADDR_W+1  frames currently recorded (0..DEPTH).
- buf_full  out  1  rec_len == DEPTH.

Behaviour:
- Reset (reset_n low at clock edge):
  - read=0, write=0, writedata_*=0.
  - rec_len=0, buf_full=0; wr_ptr=0, play_ptr=0.
  - FSM=IDLE, active_mode=00.
- FSM states IDLE, XFER, GAP.
  - IDLE: when read_ready && write_ready, latch readdata_* and mode into active_mode, compute output, then go to XFER. Otherwise stay in IDLE.
  - XFER (1 cycle): read=1, write=1, writedata_* valid and held. Buffer updates happen here. Always goes to GAP.
  - GAP (1 cycle): read=write=0, lets the codec flags settle. Always returns to IDLE.
- Throughput and latency:
  - At most one frame per 3 cycles.
  - Latency from both-ready to strobe is 1 cycle.
- Strobe pairing: read and write always assert together. Neither is ever asserted when one ready is low at IDLE sampling.
- writedata_* is held between transfers. It changes only on the IDLE→XFER edge.
- Output select, by the latched mode:
  - 00: input samples.
  - 01: zero.
  - 10: input samples (monitor while recording).
  - 11: buffer frame at play_ptr.
- Volume: each selected sample is arithmetically right-shifted (sign-extended) by vol_shift before it is registered.
- Mode entry: evaluated when the new latched mode differs from the previous active_mode.
  - Entering 10: wr_ptr=0, rec_len=0 before the first store.
  - Entering 11: play_ptr=0.
- Record (10), during XFER: if rec_len<DEPTH, store {left,right} at wr_ptr, then increment wr_ptr and rec_len.
- Record when full: once rec_len==DEPTH, further frames are passed through but not stored. buf_full=1; no wrap, no overwrite.
- Playback (11), during XFER: play_ptr increments, and wraps to 0 when play_ptr==rec_len-1.
- Playback with an empty buffer: if rec_len==0, output zero and keep play_ptr at 0.
- Buffer memory:
  - Single-port inferred RAM, DEPTH x 2*DATA_W, synchronous read.
  - Read address = play_ptr, so read data is stable by the next IDLE.
  - A write and the playback read never occur in the same mode.
- Mode changes mid-transfer are ignored until the next IDLE acceptance.
- rec_len persists across modes 00/01/11. It is cleared only by entering 10 or by reset.
- Reset mid-operation: takes effect at the next edge from any state. Strobes drop that cycle.

Test Plan:
- Passthrough timing: mode=00, vol=0, both ready held high, left=24'h123456, right=24'hFEDCBA -> read/write pulse 1 cycle after ready, then every 3rd cycle; writedata equals the input.
- Handshake gating and mute: write_ready=0, read_ready=1 -> no strobes. Then mode=01 and both ready -> writedata=0, strobes pulse.
- Volume shift: vol_shift=2, left=24'h800000, right=24'h000010 -> writedata_left=24'hE00000, writedata_right=24'h000004.
- Record overflow: DEPTH=4, mode=10, feed frames 1..6 -> rec_len goes 1,2,3,4,4,4; buf_full=1 after the 4th; all 6 frames monitored on the output.
- Playback wrap: after recording 3 frames {A,B,C}, mode=11, 7 transfers -> output A,B,C,A,B,C,A.
- Empty playback and reset: reset_n=0 during XFER -> next cycle read=write=0, rec_len=0. Then mode=11 -> output 0, play_ptr stays 0.

Source files
------------

// File: rtl/audio_loop_buffer.sv
// ----------------------------------------------------------------------------
// audio_loop_buffer : registered codec frame mover with mute, record, looped
//                     playback and arithmetic attenuation.   Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module audio_loop_buffer #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic [1:0]        mode,
  input  logic [2:0]        vol_shift,
  input  logic              read_ready,
  input  logic              write_ready,
  input  logic [DATA_W-1:0] readdata_left,
  input  logic [DATA_W-1:0] readdata_right,
  output logic              read,
  output logic              write,
  output logic [DATA_W-1:0] writedata_left,
  output logic [DATA_W-1:0] writedata_right,
  output logic [ADDR_W:0]   rec_len,
  output logic              buf_full
);

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_MUTE = 2'b01;
  localparam logic [1:0] MODE_REC  = 2'b10;
  localparam logic [1:0] MODE_PLAY = 2'b11;

  localparam logic [ADDR_W:0] DEPTH_LEN = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t              state_q,       state_d;
  logic [1:0]          active_mode_q, active_mode_d;
  logic [DATA_W-1:0]   in_left_q,     in_left_d;
  logic [DATA_W-1:0]   in_right_q,    in_right_d;
  logic [DATA_W-1:0]   wd_left_q,     wd_left_d;
  logic [DATA_W-1:0]   wd_right_q,    wd_right_d;
  logic [ADDR_W-1:0]   wr_ptr_q,      wr_ptr_d;
  logic [ADDR_W-1:0]   play_ptr_q,    play_ptr_d;
  logic [ADDR_W:0]     rec_len_q,     rec_len_d;

  logic [2*DATA_W-1:0] mem_q [DEPTH];
  logic [2*DATA_W-1:0] rd_data_q;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [2*DATA_W-1:0] mem_wdata;

  logic [DATA_W-1:0]   sel_left;
  logic [DATA_W-1:0]   sel_right;

  function automatic logic [DATA_W-1:0] attenuate(input logic [DATA_W-1:0] s,
                                                  input logic [2:0]        sh);
    return DATA_W'($signed(s) >>> sh);
  endfunction

  // Source select uses the mode being accepted, not the previous active one.
  always_comb begin
    sel_left  = readdata_left;
    sel_right = readdata_right;
    case (mode)
      MODE_MUTE: begin
        sel_left  = '0;
        sel_right = '0;
      end
      MODE_PLAY: begin
        if (rec_len_q == '0) begin
          sel_left  = '0;
          sel_right = '0;
        end else begin
          sel_left  = rd_data_q[2*DATA_W-1:DATA_W];
          sel_right = rd_data_q[DATA_W-1:0];
        end
      end
      default: begin
        sel_left  = readdata_left;
        sel_right = readdata_right;
      end
    endcase
  end

  always_comb begin
    state_d       = state_q;
    active_mode_d = active_mode_q;
    in_left_d     = in_left_q;
    in_right_d    = in_right_q;
    wd_left_d     = wd_left_q;
    wd_right_d    = wd_right_q;
    wr_ptr_d      = wr_ptr_q;
    play_ptr_d    = play_ptr_q;
    rec_len_d     = rec_len_q;
    mem_we        = 1'b0;
    mem_wdata     = {in_left_q, in_right_q};

    case (state_q)
      ST_IDLE: begin
        if (read_ready && write_ready) begin
          state_d       = ST_XFER;
          active_mode_d = mode;
          in_left_d     = readdata_left;
          in_right_d    = readdata_right;
          wd_left_d     = attenuate(sel_left, vol_shift);
          wd_right_d    = attenuate(sel_right, vol_shift);
          if (mode == MODE_REC && active_mode_q != MODE_REC) begin
            wr_ptr_d  = '0;
            rec_len_d = '0;
          end
          // Parking play_ptr at 0 outside playback keeps the RAM read of
          // frame 0 already settled when playback is next entered.
          if (mode != MODE_PLAY) begin
            play_ptr_d = '0;
          end
        end
      end

      ST_XFER: begin
        state_d = ST_GAP;
        if (active_mode_q == MODE_REC && rec_len_q < DEPTH_LEN && reset_n) begin
          mem_we    = 1'b1;
          wr_ptr_d  = wr_ptr_q + ADDR_W'(1);
          rec_len_d = rec_len_q + (ADDR_W+1)'(1);
        end
        if (active_mode_q == MODE_PLAY) begin
          if (rec_len_q == '0) begin
            play_ptr_d = '0;
          end else if ({1'b0, play_ptr_q} == rec_len_q - (ADDR_W+1)'(1)) begin
            play_ptr_d = '0;
          end else begin
            play_ptr_d = play_ptr_q + ADDR_W'(1);
          end
        end
      end

      ST_GAP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    mem_addr = mem_we ? wr_ptr_q : play_ptr_q;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      active_mode_q <= MODE_PASS;
      in_left_q     <= '0;
      in_right_q    <= '0;
      wd_left_q     <= '0;
      wd_right_q    <= '0;
      wr_ptr_q      <= '0;
      play_ptr_q    <= '0;
      rec_len_q     <= '0;
    end else begin
      state_q       <= state_d;
      active_mode_q <= active_mode_d;
      in_left_q     <= in_left_d;
      in_right_q    <= in_right_d;
      wd_left_q     <= wd_left_d;
      wd_right_q    <= wd_right_d;
      wr_ptr_q      <= wr_ptr_d;
      play_ptr_q    <= play_ptr_d;
      rec_len_q     <= rec_len_d;
    end
  end

  // Single-port, read-first RAM; contents are deliberately not reset.
  always_ff @(posedge CLOCK_50) begin
    if (mem_we) begin
      mem_q[mem_addr] <= mem_wdata;
    end
    rd_data_q <= mem_q[mem_addr];
  end

  assign read            = (state_q == ST_XFER);
  assign write           = (state_q == ST_XFER);
  assign writedata_left  = wd_left_q;
  assign writedata_right = wd_right_q;
  assign rec_len         = rec_len_q;
  assign buf_full        = (rec_len_q == DEPTH_LEN);

endmodule

`default_nettype wire
